// File: rtl/front_seq_pkg.sv
// Shared types and phase constants for the front-layer fetch sequencer.
package front_seq_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned SLOT_W  = 6;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_t;
  typedef enum logic [1:0] {WAIT, WIN, ACK} cpu_win_state_t;

  localparam logic [PHASE_W-1:0] PH_VCK   = 3'd0;
  localparam logic [PHASE_W-1:0] PH_VLK   = 3'd1;
  localparam logic [PHASE_W-1:0] PH_FCK_A = 3'd3;
  localparam logic [PHASE_W-1:0] PH_LD    = 3'd7;

  // Bit n set means FCK is high while the slot is in phase n.
  localparam logic [7:0] FCK_PH_MASK = 8'b1111_0000;

  function automatic logic fck_level(input logic [PHASE_W-1:0] ph);
    return FCK_PH_MASK[ph];
  endfunction

endpackage

// File: rtl/front_cpu_window.sv
// CPU grant/ack handshake for the shared front attribute SRAM.
module front_cpu_window
  import front_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pix_ce,
  input  logic eligible,
  input  logic abort,
  input  logic cpu_req,
  output logic front_cs_n,
  output logic cpu_ack,
  output logic grant_c
);

  cpu_win_state_t state;

  // A new window may open from WAIT or straight out of ACK; never while one is open.
  assign grant_c = (state != WIN) && pix_ce && eligible && cpu_req && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT;
      front_cs_n <= 1'b1;
      cpu_ack    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        WAIT: begin
          if (grant_c) begin
            state      <= WIN;
            front_cs_n <= 1'b0;
          end
        end
        WIN: begin
          if (abort) begin
            state      <= WAIT;
            front_cs_n <= 1'b1;
          end else if (pix_ce) begin
            state      <= ACK;
            front_cs_n <= 1'b1;
            cpu_ack    <= 1'b1;
          end
        end
        ACK: begin
          if (grant_c) begin
            state      <= WIN;
            front_cs_n <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state      <= WAIT;
          front_cs_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/front_fetch_sequencer.sv
// Front (sprite) layer fetch timing: walks attribute slots in an 8-phase pattern
// and shares the attribute SRAM with the CPU in the safe phases of each slot.
module front_fetch_sequencer
  import front_seq_pkg::*;
#(
  parameter int unsigned SLOTS        = 64,
  parameter int unsigned CPU_PH_FIRST = 2,
  parameter int unsigned CPU_PH_LAST  = 6
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       line_start,
  input  logic       cpu_req,
  output logic       cpu_ack,
  output logic       front_cs_n,
  output logic       v_c,
  output logic       vck_n,
  output logic       vlk,
  output logic       fck,
  output logic       fck_stb,
  output logic       lc,
  output logic       ld_n,
  output logic [4:0] fh,
  output logic       h3,
  output logic       busy
);

  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [PHASE_W-1:0] CPU_FIRST = PHASE_W'(CPU_PH_FIRST);
  localparam logic [PHASE_W-1:0] CPU_LAST  = PHASE_W'(CPU_PH_LAST);

  fetch_state_t        state;
  logic [PHASE_W-1:0]  phase;
  logic [SLOT_W-1:0]   slot;
  logic                slot_granted;
  logic                eligible_c;
  logic                grant_c;

  // Outside FETCH the SRAM belongs to the CPU; inside, one grant per slot in the window.
  assign eligible_c = (state != FETCH) ||
                      ((phase >= CPU_FIRST) && (phase <= CPU_LAST) && !slot_granted);

  front_cpu_window u_cpu_window (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .eligible   (eligible_c),
    .abort      (line_start),
    .cpu_req    (cpu_req),
    .front_cs_n (front_cs_n),
    .cpu_ack    (cpu_ack),
    .grant_c    (grant_c)
  );

  assign fh = slot[SLOT_W-1:1];
  assign h3 = slot[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      slot         <= '0;
      slot_granted <= 1'b0;
      busy         <= 1'b0;
      v_c          <= 1'b1;
      vck_n        <= 1'b1;
      vlk          <= 1'b0;
      fck          <= 1'b0;
      fck_stb      <= 1'b0;
      lc           <= 1'b0;
      ld_n         <= 1'b1;
    end else begin
      vlk     <= 1'b0;
      lc      <= 1'b0;
      fck_stb <= 1'b0;
      if (line_start) begin
        // Restart wins over a coincident pix_ce; phase 0 starts on the next one.
        state        <= FETCH;
        busy         <= 1'b1;
        phase        <= '0;
        slot         <= '0;
        slot_granted <= 1'b0;
        v_c          <= 1'b1;
        vck_n        <= 1'b1;
        fck          <= 1'b0;
        ld_n         <= 1'b1;
      end else if (pix_ce) begin
        if (state == FETCH) begin
          vck_n   <= (phase != PH_VCK);
          v_c     <= !((phase == PH_VCK) || (phase == PH_VLK)) || grant_c;
          lc      <= (phase == PH_VCK);
          vlk     <= (phase == PH_VLK);
          fck_stb <= (phase == PH_FCK_A) || (phase == PH_LD);
          fck     <= fck_level(phase);
          ld_n    <= (phase != PH_LD);
          phase   <= phase + PHASE_W'(1);
          if (grant_c) begin
            slot_granted <= 1'b1;
          end
          if (phase == PH_LD) begin
            slot_granted <= 1'b0;
            if (slot == LAST_SLOT) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              slot <= slot + SLOT_W'(1);
            end
          end
        end else begin
          v_c   <= 1'b1;
          vck_n <= 1'b1;
          fck   <= 1'b0;
          ld_n  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_front_fetch_sequencer.sv
// Randomised and directed bench for front_fetch_sequencer against a line-position model.
module tb_front_fetch_sequencer;

  localparam int SLOTS    = 64;
  localparam int PH_FIRST = 2;
  localparam int PH_LAST  = 6;

  logic       clk = 1'b0;
  logic       rst, pix_ce, line_start, cpu_req;
  logic       cpu_ack, front_cs_n, v_c, vck_n, vlk, fck, fck_stb, lc, ld_n, h3, busy;
  logic [4:0] fh;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  front_fetch_sequencer #(.SLOTS(SLOTS), .CPU_PH_FIRST(PH_FIRST), .CPU_PH_LAST(PH_LAST)) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .line_start(line_start), .cpu_req(cpu_req),
    .cpu_ack(cpu_ack), .front_cs_n(front_cs_n), .v_c(v_c), .vck_n(vck_n), .vlk(vlk),
    .fck(fck), .fck_stb(fck_stb), .lc(lc), .ld_n(ld_n), .fh(fh), .h3(h3), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the line is a linear count k of pix_ce since line_start; phase=k%8, slot=k/8.
  bit m_fetch = 0, m_win = 0;
  int m_k = 0, m_slot = 0, m_gslot = -1, pc = 0;
  bit m_ack = 0, m_cs_n = 1, m_v_c = 1, m_vck_n = 1, m_vlk = 0, m_fck = 0;
  bit m_fstb = 0, m_lc = 0, m_ld_n = 1, m_busy = 0;

  initial forever begin
    int ph;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_fetch = 0; m_win = 0; m_k = 0; m_slot = 0; m_gslot = -1; pc = 0;
      m_ack = 0; m_v_c = 1; m_vck_n = 1; m_vlk = 0; m_fck = 0;
      m_fstb = 0; m_lc = 0; m_ld_n = 1;
    end else begin
      m_ack = 0; m_lc = 0; m_vlk = 0; m_fstb = 0;
      if (line_start) begin
        m_fetch = 1; m_k = 0; m_slot = 0; m_gslot = -1; m_win = 0; pc = 0;
        m_v_c = 1; m_vck_n = 1; m_fck = 0; m_ld_n = 1;
      end else if (pix_ce) begin
        pc++;
        ph = m_k % 8;
        if (m_win) begin
          m_win = 0;
          m_ack = 1;
        end else if (cpu_req && (!m_fetch ||
                   (ph >= PH_FIRST && ph <= PH_LAST && m_gslot != m_k / 8))) begin
          m_win = 1;
          if (m_fetch) m_gslot = m_k / 8;
        end
        if (m_fetch) begin
          m_vck_n = (ph != 0);
          m_v_c   = (ph > 1);
          m_lc    = (ph == 0);
          m_vlk   = (ph == 1);
          m_fstb  = (ph == 3) || (ph == 7);
          m_fck   = (ph >= 4);
          m_ld_n  = (ph != 7);
          m_k++;
          if (m_k == 8 * SLOTS) m_fetch = 0;
          else m_slot = m_k / 8;
        end else begin
          m_v_c = 1; m_vck_n = 1; m_fck = 0; m_ld_n = 1;
        end
      end
    end
    m_cs_n = !m_win;
    m_busy = m_fetch;
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    check("cmp_cpu_ack", int'(cpu_ack), int'(m_ack));
    check("cmp_front_cs_n", int'(front_cs_n), int'(m_cs_n));
    check("cmp_v_c", int'(v_c), int'(m_v_c));
    check("cmp_vck_n", int'(vck_n), int'(m_vck_n));
    check("cmp_vlk", int'(vlk), int'(m_vlk));
    check("cmp_fck", int'(fck), int'(m_fck));
    check("cmp_fck_stb", int'(fck_stb), int'(m_fstb));
    check("cmp_lc", int'(lc), int'(m_lc));
    check("cmp_ld_n", int'(ld_n), int'(m_ld_n));
    check("cmp_slot", int'({fh, h3}), m_slot);
    check("cmp_busy", int'(busy), int'(m_busy));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
    $fatal(1, "watchdog");
  end

  int gap = 0, gcnt = 0, req_left = 0;
  bit rand_mode = 0;
  int ack_pc = -1, cs_pc = -1, lc_pc = -1;
  bit cs_prev = 1, ld_prev = 1;
  int cnt_vlk = 0, cnt_lc = 0, cnt_fstb = 0, cnt_ld = 0;
  int ack_log[$];

  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_ack) begin
      if (ack_pc < 0) ack_pc = pc;
      ack_log.push_back(pc);
      if (req_left > 0) req_left--;
      if (req_left == 0) cpu_req = 1'b0;
    end
    if (!front_cs_n && cs_prev && cs_pc < 0) cs_pc = pc;
    cs_prev = front_cs_n;
    if (lc && lc_pc < 0) lc_pc = pc;
    cnt_vlk  += int'(vlk);
    cnt_lc   += int'(lc);
    cnt_fstb += int'(fck_stb);
    if (!ld_n && ld_prev) cnt_ld++;
    ld_prev = ld_n;
    line_start = 1'b0;
    if (rand_mode) begin
      pix_ce = 1'($urandom_range(0, 1));
      line_start = ($urandom_range(0, 999) == 0);
      if (!cpu_req && $urandom_range(0, 7) == 0) begin
        cpu_req = 1'b1;
        req_left = 1;
      end else if (cpu_req && $urandom_range(0, 63) == 0) begin
        cpu_req = 1'b0;
      end
    end else if (gap == 0) begin
      pix_ce = 1'b0;
    end else begin
      gcnt = (gcnt + 1) % gap;
      pix_ce = (gcnt == 0);
    end
  endtask

  task automatic wait_pc(input int n);
    int b = 0;
    while (pc < n && b < 20000) begin
      tick();
      b++;
    end
    if (pc < n) check("wait_pc_timeout", pc, n);
  endtask

  task automatic start_line();
    line_start = 1'b1;
    cnt_vlk = 0; cnt_lc = 0; cnt_fstb = 0; cnt_ld = 0;
    ld_prev = ld_n;
    cs_pc = -1; ack_pc = -1; lc_pc = -1;
    tick();
  endtask

  initial begin
    int st;
    int b;
    rst = 1'b1; pix_ce = 1'b0; line_start = 1'b0; cpu_req = 1'b0;
    repeat (3) tick();
    check("reset_v_c", int'(v_c), 1);
    check("reset_ld_n", int'(ld_n), 1);
    check("reset_cs_n", int'(front_cs_n), 1);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Full line at pix_ce every 2 clk with an in-window and a late CPU request.
    gap = 2; gcnt = 0;
    start_line();
    wait_pc(42);
    cs_pc = -1; ack_pc = -1; req_left = 1; cpu_req = 1'b1;
    wait_pc(45);
    check("inwin_cs_pc", cs_pc, 43);
    check("inwin_ack_pc", ack_pc, 44);
    wait_pc(87);
    cs_pc = -1; ack_pc = -1; req_left = 1; cpu_req = 1'b1;
    wait_pc(93);
    check("late_cs_pc", cs_pc, 91);
    check("late_ack_pc", ack_pc, 92);
    wait_pc(512);
    check("line_busy_done", int'(busy), 0);
    check("line_last_slot", int'({fh, h3}), 63);
    check("line_vlk_count", cnt_vlk, 64);
    check("line_lc_count", cnt_lc, 64);
    check("line_fck_stb_count", cnt_fstb, 128);
    check("line_ld_count", cnt_ld, 64);

    // Back-to-back CPU requests while in DONE.
    gap = 1; gcnt = 0;
    tick();
    ack_log.delete();
    st = pc;
    req_left = 3; cpu_req = 1'b1;
    b = 0;
    while (ack_log.size() < 3 && b < 50) begin
      tick();
      b++;
    end
    check("b2b_ack_count", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      check("b2b_first_ack", ack_log[0], st + 2);
      check("b2b_spacing1", ack_log[1] - ack_log[0], 2);
      check("b2b_spacing2", ack_log[2] - ack_log[1], 2);
    end

    // Restart at slot 30 phase 4 with a window open, coincident with pix_ce.
    start_line();
    wait_pc(243);
    req_left = 1; cpu_req = 1'b1;
    wait_pc(244);
    check("restart_win_open", int'(front_cs_n), 0);
    start_line();
    tick();
    wait_pc(6);
    check("restart_slot", int'({fh, h3}), 0);
    check("restart_lc_pc", lc_pc, 1);
    check("restart_cs_pc", cs_pc, 3);
    check("restart_ack_pc", ack_pc, 4);
    wait_pc(512);

    // Random traffic.
    line_start = 1'b1;
    rand_mode = 1;
    repeat (4000) tick();
    rand_mode = 0;
    cpu_req = 1'b0;
    gap = 2; gcnt = 0;
    repeat (6) tick();

    // Async reset mid-FETCH with a grant open.
    start_line();
    wait_pc(10);
    req_left = 1; cpu_req = 1'b1;
    wait_pc(11);
    check("rstmid_win_open", int'(front_cs_n), 0);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("rstmid_cs_n", int'(front_cs_n), 1);
    check("rstmid_ld_n", int'(ld_n), 1);
    check("rstmid_v_c", int'(v_c), 1);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_vck_n", int'(vck_n), 1);
    repeat (2) tick();
    rst = 1'b0;
    ack_log.delete();
    repeat (20) tick();
    check("rstmid_no_ack", ack_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/front_fetch_sequencer.md
Name: front_fetch_sequencer

Overview:
- Timing controller for the front (sprite) layer.
- Per scanline it walks the sprite attribute slots: it drives the scan address and the attribute/tile/ROM/shifter strobes in a fixed 8-phase pattern per slot.
- It shares the 4-bank front attribute SRAM between the video scan and CPU accesses, granting the CPU only in safe phases.
- It sits between the video timing generator and the front-layer datapath, and drives that datapath's V_C, VCKn, VLK, FCK, LC, LD and FRONT_VIDEO_CSn inputs.

Parameters:
- SLOTS, 64, sprite slots fetched per line (slot index = {FH[4:0],H3}); legal 1..64.
- CPU_PH_FIRST, 2, first phase of the CPU window within a slot.
- CPU_PH_LAST, 6, last phase of the CPU window within a slot.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pix_ce  in  1  pixel clock enable; the phase counter advances only on pix_ce
- line_start  in  1  one-clk pulse at the start of each line's sprite fetch
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_ack  out  1  one-clk pulse; the granted access is complete
- front_cs_n  out  1  active-low SRAM CPU chip-select window (FRONT_VIDEO_CSn)
- v_c  out  1  SRAM address select: 0 = video scan, 1 = CPU
- vck_n  out  1  active-low video read of the attribute SRAM
- vlk  out  1  attribute latch strobe (VLK)
- fck  out  1  ROM half-select level, also used as a cen
- fck_stb  out  1  FCK register strobe
- lc  out  1  colour latch strobe
- ld_n  out  1  active-low shifter load (LD)
- fh  out  5  slot index [5:1]
- h3  out  1  slot index [0]
- busy  out  1  1 while in state FETCH

Behaviour:
- Reset (async, while rst=1) forces:
  - state IDLE, phase=0, slot=0
  - v_c=1, vck_n=1, vlk=0, fck=0, fck_stb=0, lc=0, ld_n=1
  - front_cs_n=1, cpu_ack=0, fh=0, h3=0, busy=0
  - any in-flight grant is dropped.
- States are IDLE, FETCH and DONE.
  - IDLE -> FETCH on line_start.
  - FETCH -> DONE after the phase-7 pix_ce of slot SLOTS-1.
  - DONE -> FETCH on line_start.
- line_start in any state (including mid-FETCH) restarts the fetch: phase=0, slot=0, state FETCH, effective the next clk. Any CPU grant in progress is aborted: front_cs_n goes to 1 and no ack is issued; cpu_req stays pending.
- In FETCH:
  - The 3-bit phase counter increments on each pix_ce and wraps 7->0.
  - On the wrap the slot counter increments.
  - {fh,h3}=slot, registered.
- Video strobes in FETCH. All are registered outputs and valid on the clk after the qualifying pix_ce.
  - phase 0: v_c=0, vck_n=0 (video read); lc=1 for one clk.
  - phase 1: v_c=0; vlk=1 for one clk.
  - phase 3 and phase 7: fck_stb=1 for one clk.
  - fck = 1 for phases 4..7, else 0.
  - phase 7: ld_n=0; ld_n=1 otherwise.
- CPU arbitration in FETCH:
  - Only phases CPU_PH_FIRST..CPU_PH_LAST are eligible, with at most one grant per slot.
  - If cpu_req=1 at an eligible pix_ce, and no grant has been given this slot, the access is granted:
    - v_c=1 and front_cs_n=0 for exactly one phase (until the next pix_ce);
    - cpu_ack pulses on the clk the window closes.
  - A request arriving after CPU_PH_LAST waits for the next slot.
- CPU arbitration in IDLE/DONE:
  - v_c=1 and all video strobes are inactive.
  - A pending cpu_req is granted on the next pix_ce: window of one phase, then ack.
  - Back-to-back requests are allowed, one per two pix_ce: one window phase plus one idle phase.
- Simultaneous line_start and pix_ce: line_start wins, and phase 0 begins on the following pix_ce.
- cpu_req deasserted before ack: the grant still completes and ack is issued; the CPU ignores it.
- cpu_ack never coincides with vck_n=0.

Decomposition:
- Shared package front_seq_pkg holds:
  - typedef enum fetch_state_t {IDLE,FETCH,DONE};
  - phase constants PH_VCK=0, PH_VLK=1, PH_LD=7, FCK_PH_MASK.
- One sub-module, front_cpu_window: the grant/ack handshake FSM (WAIT, WIN, ACK). It takes an "eligible" input from the sequencer.

Test Plan:
- Reset: assert rst mid-FETCH with a grant open -> all outputs immediately at reset values (front_cs_n=1, ld_n=1, v_c=1, busy=0); after release, no ack.
- Full line: SLOTS=64, pix_ce every 2 clk, line_start -> exactly 64 vlk, 64 lc, 128 fck_stb and 64 ld_n pulses; {fh,h3} steps 0..63; busy falls after slot 63 phase 7.
- CPU in window: cpu_req raised at slot 5 phase 1 -> front_cs_n=0 during phase 2, cpu_ack at phase-3 entry; v_c=0 again at next phase 0.
- CPU late: cpu_req raised at phase 7 -> grant at phase 2 of the next slot; no front_cs_n low at phases 0/1.
- Restart: line_start at slot 30 phase 4 with a grant open -> no ack, slot=0, phase 0 strobes (vck_n=0, lc) on the next pix_ce; the pending req is granted at the new slot 0 phase 2.
- IDLE throughput: 3 back-to-back requests in DONE -> 3 acks spaced 2 pix_ce apart; vck_n stays 1.
